// File: rtl/bt_cmd_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bt_cmd_pkg : drive-command byte set and receiver FSM encoding
// Rev 1.0
// ---------------------------------------------------------------------------
package bt_cmd_pkg;

    localparam logic [7:0] CMD_STOP  = 8'hC0;
    localparam logic [7:0] CMD_FWD   = 8'hF9;
    localparam logic [7:0] CMD_LEFT  = 8'hB0;
    localparam logic [7:0] CMD_RIGHT = 8'h99;
    localparam logic [7:0] CMD_BACK  = 8'hA4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    function automatic logic is_legal_cmd(input logic [7:0] b);
        logic legal;
        legal = 1'b0;
        case (b)
            CMD_STOP, CMD_FWD, CMD_LEFT, CMD_RIGHT, CMD_BACK: legal = 1'b1;
            default:                                          legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_8n1.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_8n1 : 2-FF synchronised 8N1 receiver with mid-bit sampling
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_rx_8n1
    import bt_cmd_pkg::*;
#(
    parameter int BIT_CYC = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       frame_err
);

    localparam int CNT_W = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_CYC / 2 - 1);

    logic [1:0]       sync;
    logic             rxs;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shreg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rxd};
        end
    end

    assign rxs = sync[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            idx       <= 3'd0;
            shreg     <= 8'h00;
            rx_byte   <= 8'h00;
            byte_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rxs) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end
                ST_START: begin
                    // Re-check at mid start bit so short low glitches are ignored
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        idx <= 3'd0;
                        state <= rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rxs, shreg[7:1]};
                        if (idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rxs) begin
                            rx_byte   <= shreg;
                            byte_done <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rxs) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bt_cmd_uart_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bt_cmd_uart_rx : BT UART command receiver with validation and link watchdog
// Rev 1.0
// ---------------------------------------------------------------------------
module bt_cmd_uart_rx
    import bt_cmd_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int BAUD        = 9600,
    parameter int BIT_CYC     = CLK_HZ / BAUD,
    parameter int TIMEOUT_CYC = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] cmd,
    output logic       cmd_valid,
    output logic       frame_err,
    output logic       bad_cmd,
    output logic       link_lost
);

    localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [7:0]      rx_byte;
    logic            byte_done;
    logic            legal;
    logic [WD_W-1:0] wd;

    uart_rx_8n1 #(
        .BIT_CYC (BIT_CYC)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rx_byte   (rx_byte),
        .byte_done (byte_done),
        .frame_err (frame_err)
    );

    assign legal = is_legal_cmd(rx_byte);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd       <= CMD_STOP;
            cmd_valid <= 1'b0;
            bad_cmd   <= 1'b0;
            link_lost <= 1'b0;
            wd        <= '0;
        end else begin
            cmd_valid <= 1'b0;
            bad_cmd   <= 1'b0;
            // A fresh legal command takes priority over a coincident timeout
            if (byte_done && legal) begin
                cmd       <= rx_byte;
                cmd_valid <= 1'b1;
                link_lost <= 1'b0;
                wd        <= '0;
            end else begin
                if (byte_done) begin
                    bad_cmd <= 1'b1;
                end
                if (wd == WD_LAST) begin
                    cmd       <= CMD_STOP;
                    link_lost <= 1'b1;
                end else begin
                    wd <= wd + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/bt_cmd_uart_rx.md
Name: bt_cmd_uart_rx

Overview:
- Receives the serial byte stream from the Bluetooth UART module (HC-05 class, 8N1) on `rxd`.
- Validates each byte against the drive-command set and presents the last valid command as a held 8-bit bus, `cmd`. `cmd` feeds the motor/steering PWM controller's command input directly.
- Includes a link watchdog that forces the STOP command when no valid command arrives for a set time.
- Sits between the `rxd` pad and the PWM controller, in the 50 MHz `clk` domain.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency.
- BAUD, 9600, UART bit rate.
- BIT_CYC, CLK_HZ/BAUD (5208), clocks per bit (derived; overridable for sim).
- TIMEOUT_CYC, 25_000_000, clocks without a valid command before failsafe (500 ms).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset, asynchronous, active-low.
- rxd  in  1  asynchronous UART line from BT module; idle high.
- cmd  out  8  last valid command byte, held.
- cmd_valid  out  1  one-clk pulse when cmd is (re)loaded from a received byte.
- frame_err  out  1  one-clk pulse when the stop bit is sampled low.
- bad_cmd  out  1  one-clk pulse when a well-framed byte is not in the command set.
- link_lost  out  1  level, high while the watchdog failsafe is active.

Behaviour:
- Reset (rst=0, async):
  - cmd=0xC0 (STOP); cmd_valid, frame_err, bad_cmd and link_lost = 0.
  - FSM=IDLE; sync FFs=1; bit counter, bit index and watchdog = 0.
- Input sync: 2-FF synchronizer on rxd; all logic uses the synchronized value `rxs`.
- Command set (shared constants):
  - 0xC0 STOP, 0xF9 FWD, 0xB0 LEFT, 0x99 RIGHT, 0xA4 BACK.
  - Any other byte is illegal.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: rxs=0 -> START with cnt=0.
  - START: cnt counts up; at cnt=BIT_CYC/2-1, sample rxs. If 0 -> DATA with cnt=0, idx=0. If 1 -> IDLE (glitch rejected, no pulses).
  - DATA: at cnt=BIT_CYC-1, sample rxs into shift reg, LSB first, cnt=0, idx++. After idx=7 is sampled -> STOP.
  - STOP: at cnt=BIT_CYC-1, sample rxs. If 1 -> byte done, then IDLE. If 0 -> frame_err pulse, byte discarded -> BREAK.
  - BREAK: wait for rxs=1, then IDLE. Guards against held-low lines and prevents re-triggering on a break.
- Byte done:
  - Legal byte: cmd<=byte and cmd_valid=1 on the next clk edge; watchdog cleared; link_lost<=0.
  - Illegal byte: bad_cmd=1; cmd unchanged; watchdog not cleared.
  - Receiving the same legal byte again still pulses cmd_valid.
- Latency: cmd updates 1 clk after the stop-bit sample, about 9.5 bit times after the start edge, plus 2 sync clks.
- Watchdog:
  - Increments every clk while not saturated.
  - At count = TIMEOUT_CYC-1: cmd<=0xC0, link_lost<=1, counter holds. No cmd_valid pulse for the forced STOP.
  - A valid command arriving in the same cycle as the timeout wins: cmd=new byte, link_lost=0, counter=0.
- Widths: cnt is $clog2(BIT_CYC) bits; idx is 3 bits; watchdog is $clog2(TIMEOUT_CYC) bits. Counters never wrap; each is cleared explicitly.
- Pulse outputs are registered, exactly 1 clk wide, and mutually exclusive per byte.
- Reset mid-frame: everything returns to reset values immediately. A partial byte is lost with no pulses. The next falling edge after reset release starts a fresh frame.

Decomposition:
- Package bt_cmd_pkg: command byte constants (CMD_STOP, CMD_FWD, CMD_LEFT, CMD_RIGHT, CMD_BACK), FSM state encoding, and an is_legal_cmd function. The PWM controller uses the same package.
- One sub-module: uart_rx_8n1. It contains the sync, the FSM, the bit/sample counters and the shift register, and outputs byte[7:0], byte_done and frame_err.
- The top level holds command validation, the cmd register and the watchdog.

Test Plan (sim overrides BIT_CYC=16, TIMEOUT_CYC=2000 unless noted):
- Send 0xF9, 8N1 -> cmd=0xF9; one cmd_valid pulse about 152 clks after the start edge; frame_err=0 and bad_cmd=0.
- Send 0xB0 then 0x99 back-to-back, one stop bit each -> cmd=0xB0 then 0x99; two cmd_valid pulses 160 clks apart.
- Low glitch of 5 clks on idle rxd -> FSM returns to IDLE; no pulses; cmd unchanged.
- Send 0xA4 with stop bit=0, line held low 100 clks -> frame_err pulses once; cmd unchanged; no new frame until rxd goes high. A following 0xA4 is then accepted.
- Send 0x55 -> bad_cmd pulses once; cmd unchanged. After 2000 clks idle -> cmd=0xC0 and link_lost=1. Then send 0xF9 -> link_lost=0 and cmd=0xF9.
- Assert rst for 3 clks during DATA bit 4 of 0xF9 -> all outputs at reset values; no pulses. A next full 0x99 is received correctly.
